rf_wb_arbiter: RTL and testbench
================================

# rf_wb_arbiter

Write-back arbiter and scoreboard for the 32x32 register file. It shares the file's single write port (RF_W/RDC/RD) fairly among several producers: ALU, load unit and multi-cycle mul/div. It also tracks which destination registers have an outstanding write, so issue logic can stall on RAW hazards. It sits between the execution units and the register file and drives its write port directly.

## Interface
- N_REQ, 3, number of write-back requesters (2..8); index 0 = ALU, 1 = load, 2 = mul/div
- ADDR_W, 5, register address width
- DATA_W, 32, write data width
- CLK  in  1  clock, all state updates on rising edge
- RST_N  in  1  reset, asynchronous, active-low
- REQ_V  in  N_REQ  per-requester write request valid
- REQ_ADDR  in  N_REQ*ADDR_W  per-requester destination register, requester i at bits [i*ADDR_W +: ADDR_W]
- REQ_DATA  in  N_REQ*DATA_W  per-requester write data, same packing as REQ_ADDR
- REQ_RDY  out  N_REQ  one-hot grant, combinational from REQ_V and the round-robin pointer
- RESV_V  in  1  issue reserves a destination register
- RESV_ADDR  in  ADDR_W  register being reserved
- RSC, RTC  in  ADDR_W each  source registers to check
- BUSY_RS, BUSY_RT  out  1 each  source has a pending write (combinational lookup)
- RF_W  out  1  register-file write enable (registered)
- RDC  out  ADDR_W  register-file write address (registered)
- RD  out  DATA_W  register-file write data (registered)
- RESV_ERR  out  1  sticky: a reservation hit an already-busy register

## Operation
- Handshake: requester i transfers when REQ_V[i] && REQ_RDY[i]. REQ_V, REQ_ADDR and REQ_DATA hold stable until the transfer. At most one REQ_RDY bit is high per cycle, and only on a bit whose REQ_V is high.
- Arbitration: round-robin with pointer PTR (0..N_REQ-1). Search order is PTR, PTR+1, … mod N_REQ; the first valid requester wins. After a grant to i, PTR <= (i+1) mod N_REQ. PTR is unchanged when nothing is granted.
- Output stage: on a transfer, RF_W <= (addr != 0), RDC <= addr, RD <= data. With no transfer, RF_W <= 0 and RDC/RD hold their values.
- Writes to $0 complete the handshake but never raise RF_W.
- Scoreboard: 32-bit BUSY vector; bit 0 is forced to 0.
  - RESV_V with a nonzero RESV_ADDR sets BUSY[RESV_ADDR].
  - BUSY[RDC] clears at the rising edge that ends the cycle in which RF_W=1.
  - BUSY_RS = BUSY[RSC]; BUSY_RT = BUSY[RTC].
- Simultaneous set and clear of the same register: set wins, because a new producer supersedes the old one.
- RESV_V on a register that is already busy: the bit stays set and RESV_ERR <= 1, held until reset.

## Timing
- Reset (RST_N=0, any time, including mid-transfer): PTR=0, RF_W=0, RDC=0, RD=0, BUSY=0, RESV_ERR=0. REQ_RDY is 0 while RST_N=0.
- Latency: a handshake at edge t produces RF_W/RDC/RD valid for exactly the cycle following edge t. The register file commits on the falling edge inside that cycle.
- BUSY clears one edge after RF_W, so a BUSY_RS=0 reader always sees the committed value.
- Throughput: one write per cycle sustained. A continuously valid requester waits at most N_REQ-1 cycles.
- With no REQ_V asserted, RF_W=0 in the next cycle.

## Structure
- Shared package (rf_pkg): ADDR_W, DATA_W, REG_COUNT=32, requester index constants (REQ_ALU=0, REQ_LOAD=1, REQ_MDU=2).
- Sub-module rr_arbiter (N-input round-robin, outputs a one-hot grant and the next pointer), instantiated once. The scoreboard and output register stay in the top level.

## Test plan
- Single ALU write: REQ_V=001, addr 8, data 0xDEADBEEF. Expect REQ_RDY=001 in the same cycle; next cycle RF_W=1, RDC=8, RD=0xDEADBEEF; the cycle after, RF_W=0.
- All three held valid with addrs 1/2/3, PTR=0 after reset. Expect grants in order 0, 1, 2, 0…; RDC sequence 1, 2, 3, 1; no bubbles.
- Write to $0, data 0x1234. Expect the handshake completes, RF_W stays 0, and BUSY[0] reads 0 even after RESV_V with addr 0.
- RESV addr 9, then load writes 9. Expect BUSY_RS=1 (RSC=9) until one edge after the RF_W=1 cycle with RDC=9, then 0.
- RESV addr 9 in the same cycle that RF_W writes 9. Expect BUSY[9] stays 1. A second RESV on 9 while busy sets RESV_ERR=1, held until reset.
- RST_N pulled low mid-stream with RF_W=1. Expect RF_W, RDC, RD, BUSY and PTR at 0 immediately (asynchronous); after release, requester 0 wins first.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared constants for the register-file write-back path.
package rf_pkg;

   localparam int ADDR_W    = 5;
   localparam int DATA_W    = 32;
   localparam int REG_COUNT = 32;

   // Requester slots on the write-back arbiter
   localparam int REQ_ALU  = 0;
   localparam int REQ_LOAD = 1;
   localparam int REQ_MDU  = 2;

endpackage : rf_pkg

// File: rtl/rf_wb_arbiter_rr.sv
// N-input round-robin arbiter: one-hot grant starting the search at ptr_i,
// plus the pointer value to load after this cycle's grant.
module rr_arbiter #(
   parameter  int N  = 3,
   localparam int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic          gnt_v_o,
   output logic [PW-1:0] idx_o,
   output logic [PW-1:0] ptr_next_o
);

   int cand;
   int nxt;

   // Scan ptr, ptr+1, ... mod N; first valid requester wins
   always_comb begin
      gnt_o      = '0;
      gnt_v_o    = 1'b0;
      idx_o      = '0;
      ptr_next_o = ptr_i;
      cand       = 0;
      nxt        = 0;
      for (int k = 0; k < N; k++) begin
         cand = (int'(ptr_i) + k) % N;
         if (!gnt_v_o && req_i[cand]) begin
            gnt_v_o     = 1'b1;
            gnt_o[cand] = 1'b1;
            idx_o       = PW'(cand);
         end
      end
      if (gnt_v_o) begin
         nxt = int'(idx_o) + 1;
         if (nxt >= N) begin
            nxt = 0;
         end
         ptr_next_o = PW'(nxt);
      end
   end

endmodule : rr_arbiter

// File: rtl/rf_wb_arbiter.sv
// Register-file write-back arbiter and destination scoreboard.
// Shares the single RF write port among N_REQ producers and tracks which
// destination registers still have a write outstanding.
module rf_wb_arbiter #(
   parameter  int N_REQ  = 3,
   parameter  int ADDR_W = 5,
   parameter  int DATA_W = 32,
   localparam int PW     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                    CLK,
   input  logic                    RST_N,
   input  logic [N_REQ-1:0]        REQ_V,
   input  logic [N_REQ*ADDR_W-1:0] REQ_ADDR,
   input  logic [N_REQ*DATA_W-1:0] REQ_DATA,
   output logic [N_REQ-1:0]        REQ_RDY,
   input  logic                    RESV_V,
   input  logic [ADDR_W-1:0]       RESV_ADDR,
   input  logic [ADDR_W-1:0]       RSC,
   input  logic [ADDR_W-1:0]       RTC,
   output logic                    BUSY_RS,
   output logic                    BUSY_RT,
   output logic                    RF_W,
   output logic [ADDR_W-1:0]       RDC,
   output logic [DATA_W-1:0]       RD,
   output logic                    RESV_ERR
);

   import rf_pkg::*;

   localparam int NREG = 1 << ADDR_W;

   logic [PW-1:0]     ptr_q, ptr_d, ptr_nxt;
   logic              rf_w_q, rf_w_d;
   logic [ADDR_W-1:0] rdc_q, rdc_d;
   logic [DATA_W-1:0] rd_q, rd_d;
   logic [NREG-1:0]   busy_q, busy_d;
   logic              resv_err_q, resv_err_d;

   logic [N_REQ-1:0]  gnt;
   logic              gnt_v;
   logic [PW-1:0]     gnt_idx;
   logic              xfer;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data;
   logic              resv_nz;

   rr_arbiter #(.N(N_REQ)) u_rr (
      .req_i      (REQ_V),
      .ptr_i      (ptr_q),
      .gnt_o      (gnt),
      .gnt_v_o    (gnt_v),
      .idx_o      (gnt_idx),
      .ptr_next_o (ptr_nxt)
   );

   // Grants are suppressed while reset is asserted so no handshake can complete
   assign REQ_RDY = RST_N ? gnt : '0;
   assign xfer    = RST_N & gnt_v;
   assign resv_nz = RESV_V && (RESV_ADDR != '0);

   // Select the granted requester's address and data
   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt[i]) begin
            sel_addr = REQ_ADDR[i*ADDR_W +: ADDR_W];
            sel_data = REQ_DATA[i*DATA_W +: DATA_W];
         end
      end
   end

   // Output stage and pointer next state; $0 completes handshake without a write
   always_comb begin
      ptr_d  = ptr_q;
      rf_w_d = 1'b0;
      rdc_d  = rdc_q;
      rd_d   = rd_q;
      if (xfer) begin
         ptr_d  = ptr_nxt;
         rf_w_d = (sel_addr != '0);
         rdc_d  = sel_addr;
         rd_d   = sel_data;
      end
   end

   // Scoreboard next state: clear after the write cycle, set on reservation (set wins)
   always_comb begin
      busy_d = busy_q;
      if (rf_w_q) begin
         busy_d[rdc_q] = 1'b0;
      end
      if (resv_nz) begin
         busy_d[RESV_ADDR] = 1'b1;
      end
      busy_d[0]  = 1'b0;
      resv_err_d = resv_err_q | (resv_nz & busy_q[RESV_ADDR]);
   end

   // State registers
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         ptr_q      <= '0;
         rf_w_q     <= 1'b0;
         rdc_q      <= '0;
         rd_q       <= '0;
         busy_q     <= '0;
         resv_err_q <= 1'b0;
      end else begin
         ptr_q      <= ptr_d;
         rf_w_q     <= rf_w_d;
         rdc_q      <= rdc_d;
         rd_q       <= rd_d;
         busy_q     <= busy_d;
         resv_err_q <= resv_err_d;
      end
   end

   assign RF_W     = rf_w_q;
   assign RDC      = rdc_q;
   assign RD       = rd_q;
   assign RESV_ERR = resv_err_q;
   assign BUSY_RS  = busy_q[RSC];
   assign BUSY_RT  = busy_q[RTC];

endmodule : rf_wb_arbiter

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: grants and writes predicted from a
// round-robin reference, expected writes queued at handshake, popped next cycle.
module tb_rf_wb_arbiter;

   localparam int N  = 3;
   localparam int AW = 5;
   localparam int DW = 32;

   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } exp_t;

   logic            CLK = 1'b0;
   logic            RST_N;
   logic [N-1:0]    REQ_V;
   logic [N*AW-1:0] REQ_ADDR;
   logic [N*DW-1:0] REQ_DATA;
   logic [N-1:0]    REQ_RDY;
   logic            RESV_V;
   logic [AW-1:0]   RESV_ADDR;
   logic [AW-1:0]   RSC, RTC;
   logic            BUSY_RS, BUSY_RT;
   logic            RF_W;
   logic [AW-1:0]   RDC;
   logic [DW-1:0]   RD;
   logic            RESV_ERR;

   int    n_chk  = 0;
   int    n_pass = 0;
   exp_t  exp_q[$];
   int    m_ptr;
   logic  m_rfw;
   logic [AW-1:0] m_rdc;
   logic [31:0]   m_busy;
   logic          m_err;

   rf_wb_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
      .CLK(CLK), .RST_N(RST_N), .REQ_V(REQ_V), .REQ_ADDR(REQ_ADDR),
      .REQ_DATA(REQ_DATA), .REQ_RDY(REQ_RDY), .RESV_V(RESV_V),
      .RESV_ADDR(RESV_ADDR), .RSC(RSC), .RTC(RTC), .BUSY_RS(BUSY_RS),
      .BUSY_RT(BUSY_RT), .RF_W(RF_W), .RDC(RDC), .RD(RD), .RESV_ERR(RESV_ERR)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
   endtask

   task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
      REQ_V[i] = v;
      REQ_ADDR[i*AW +: AW] = a;
      REQ_DATA[i*DW +: DW] = d;
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_ptr  = 0;
      m_rfw  = 1'b0;
      m_rdc  = '0;
      m_busy = '0;
      m_err  = 1'b0;
   endtask

   // One clock: check comb outputs, predict, then check registered outputs
   task automatic cycle();
      logic [N-1:0] eg;
      logic [31:0]  nb;
      logic         ne;
      int           gi;
      exp_t         e;
      #1;
      eg = '0;
      gi = -1;
      for (int k = 0; k < N; k++) begin
         int c;
         c = (m_ptr + k) % N;
         if (gi < 0 && REQ_V[c]) gi = c;
      end
      if (gi >= 0) begin
         eg[gi] = 1'b1;
         e.addr = REQ_ADDR[gi*AW +: AW];
         e.data = REQ_DATA[gi*DW +: DW];
         e.we   = (e.addr != '0);
         exp_q.push_back(e);
         m_ptr = (gi + 1) % N;
      end
      chk("req_rdy", REQ_RDY, eg);
      chk("busy_rs", BUSY_RS, m_busy[RSC]);
      chk("busy_rt", BUSY_RT, m_busy[RTC]);
      nb = m_busy;
      ne = m_err;
      if (m_rfw) nb[m_rdc] = 1'b0;
      if (RESV_V && RESV_ADDR != '0) begin
         if (m_busy[RESV_ADDR]) ne = 1'b1;
         nb[RESV_ADDR] = 1'b1;
      end
      nb[0] = 1'b0;
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("rf_w", RF_W, e.we);
         chk("rdc", RDC, e.addr);
         chk("rd", RD, e.data);
         m_rfw = e.we;
         m_rdc = e.addr;
      end else begin
         chk("rf_w_idle", RF_W, 1'b0);
         m_rfw = 1'b0;
      end
      m_busy = nb;
      m_err  = ne;
      chk("resv_err", RESV_ERR, m_err);
      @(negedge CLK);
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RST_N = 1'b0;
      #2;
      model_reset();
      @(negedge CLK);
      RST_N = 1'b1;
   endtask

   initial begin
      RST_N = 1'b0; REQ_V = '0; REQ_ADDR = '0; REQ_DATA = '0;
      RESV_V = 1'b0; RESV_ADDR = '0; RSC = '0; RTC = '0;
      model_reset();
      REQ_V = 3'b111;
      #3;
      chk("rst_rdy", REQ_RDY, 3'b000);
      chk("rst_rf_w", RF_W, 1'b0);
      chk("rst_rdc", RDC, 5'd0);
      chk("rst_rd", RD, 32'd0);
      chk("rst_err", RESV_ERR, 1'b0);
      REQ_V = '0;
      @(negedge CLK);
      RST_N = 1'b1;

      // Single ALU write
      set_req(0, 1'b1, 5'd8, 32'hDEADBEEF);
      cycle();
      set_req(0, 1'b0, 5'd0, 32'd0);
      cycle();
      cycle();

      // All three held valid from PTR=0: grants 0,1,2,0,1,2 with no bubbles
      do_reset();
      set_req(0, 1'b1, 5'd1, 32'h1111_0001);
      set_req(1, 1'b1, 5'd2, 32'h2222_0002);
      set_req(2, 1'b1, 5'd3, 32'h3333_0003);
      for (int i = 0; i < 6; i++) cycle();
      REQ_V = '0;
      cycle();

      // Write to $0 plus a reservation of $0
      set_req(0, 1'b1, 5'd0, 32'h0000_1234);
      RESV_V = 1'b1; RESV_ADDR = 5'd0; RSC = 5'd0;
      cycle();
      set_req(0, 1'b0, 5'd0, 32'd0);
      RESV_V = 1'b0;
      cycle();
      cycle();

      // Reserve 9, then the load unit writes 9
      RESV_V = 1'b1; RESV_ADDR = 5'd9; RSC = 5'd9; RTC = 5'd8;
      cycle();
      RESV_V = 1'b0;
      set_req(1, 1'b1, 5'd9, 32'hCAFE_0009);
      cycle();
      set_req(1, 1'b0, 5'd0, 32'd0);
      cycle();
      cycle();
      cycle();

      // Reserve 9 in the same cycle the write of 9 is on the port; then reserve again
      set_req(2, 1'b1, 5'd9, 32'hBEEF_0909);
      cycle();
      set_req(2, 1'b0, 5'd0, 32'd0);
      RESV_V = 1'b1; RESV_ADDR = 5'd9;
      cycle();
      RESV_V = 1'b0;
      cycle();
      RESV_V = 1'b1;
      cycle();
      RESV_V = 1'b0;
      cycle();
      cycle();

      // Asynchronous reset mid-stream while RF_W=1
      set_req(0, 1'b1, 5'd4, 32'hA5A5_0004);
      set_req(1, 1'b1, 5'd5, 32'hA5A5_0005);
      set_req(2, 1'b1, 5'd6, 32'hA5A5_0006);
      cycle();
      cycle();
      chk("pre_rst_rf_w", RF_W, 1'b1);
      #2;
      RST_N = 1'b0;
      #1;
      chk("arst_rf_w", RF_W, 1'b0);
      chk("arst_rdc", RDC, 5'd0);
      chk("arst_rd", RD, 32'd0);
      chk("arst_busy", BUSY_RS, 1'b0);
      chk("arst_err", RESV_ERR, 1'b0);
      chk("arst_rdy", REQ_RDY, 3'b000);
      model_reset();
      @(negedge CLK);
      RST_N = 1'b1;
      cycle();
      cycle();
      REQ_V = '0;
      cycle();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule : tb_rf_wb_arbiter
